// File: rtl/ioctl_ddr_writer_if.sv
// Bundle of the hps_io ROM download port and the DDR3 write port seen by the writer.
// The writer takes the master side: it drives the DDR request and the ioctl stall.
interface ioctl_ddr_writer_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [26:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wait;

    logic        ddr_wr;
    logic [31:0] ddr_addr;
    logic [7:0]  ddr_burstLength;
    logic [7:0]  ddr_mask;
    logic [63:0] ddr_din;
    logic        ddr_waitReq;

    modport master (
        input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
        input  ddr_waitReq,
        output ioctl_wait,
        output ddr_wr, ddr_addr, ddr_burstLength, ddr_mask, ddr_din
    );

    modport slave (
        output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
        output ddr_waitReq,
        input  ioctl_wait,
        input  ddr_wr, ddr_addr, ddr_burstLength, ddr_mask, ddr_din
    );
endinterface

// File: rtl/ioctl_ddr_writer.sv
// Packs 16-bit ioctl download words into an aligned burst buffer of 64-bit beats
// and writes each full or partial burst to DDR, stalling hps_io while it does so.
module ioctl_ddr_writer #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          BURST_LEN = 8,
    parameter logic [7:0]  INDEX     = 8'd0
) (
    input  logic               clk,
    input  logic               rst,
    ioctl_ddr_writer_if.master bus,
    output logic               busy,
    output logic               done
);
    localparam int BW    = $clog2(BURST_LEN);
    localparam int BI_W  = (BW == 0) ? 1 : BW;
    localparam int TAG_W = 24 - BW;
    localparam logic [26:0]     LOW_ONES  = 27'(8 * BURST_LEN - 2);
    localparam logic [BI_W-1:0] LAST_BEAT = BI_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, FILL, FLUSH, POST} state_t;

    function automatic logic [BI_W-1:0] beat_of(input logic [26:0] a);
        return BI_W'((a >> 3) & 27'(BURST_LEN - 1));
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [26:0] a);
        return TAG_W'(a >> (3 + BW));
    endfunction

    function automatic logic is_last(input logic [26:0] a);
        return (a & LOW_ONES) == LOW_ONES;
    endfunction

    state_t           state;
    logic [TAG_W-1:0] tag_q;
    logic [BI_W-1:0]  beat_cnt;
    logic [63:0]      buf_data [BURST_LEN];
    logic [7:0]       buf_mask [BURST_LEN];
    logic             pend_vld;
    logic [26:0]      pend_addr;
    logic [15:0]      pend_dout;
    logic             final_q;
    logic             flush_first;
    logic             wait_q;
    logic             wr_q;
    logic             done_q;

    logic        wr_req;
    logic        wr_acc;
    logic        same_tag;
    logic        beat_acc;
    logic        late_cap;
    logic        st_en;
    logic [26:0] st_addr;
    logic [15:0] st_dout;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = bus.ioctl_addr[0];

    assign wr_req   = bus.ioctl_wr & bus.ioctl_download & (bus.ioctl_index == INDEX);
    assign wr_acc   = wr_req & ~wait_q;
    assign same_tag = tag_of(bus.ioctl_addr) == tag_q;
    assign beat_acc = wr_q & ~bus.ddr_waitReq;
    // hps_io may still strobe in the cycle the stall first rises; park that word.
    assign late_cap = (state == FLUSH) & flush_first & wr_req & ~pend_vld;

    always_comb begin
        st_en   = 1'b0;
        st_addr = bus.ioctl_addr;
        st_dout = bus.ioctl_dout;
        case (state)
            IDLE:    st_en = wr_acc;
            FILL:    st_en = wr_acc & same_tag;
            POST: begin
                st_en   = pend_vld;
                st_addr = pend_addr;
                st_dout = pend_dout;
            end
            default: st_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tag_q       <= '0;
            beat_cnt    <= '0;
            pend_vld    <= 1'b0;
            pend_addr   <= '0;
            pend_dout   <= '0;
            final_q     <= 1'b0;
            flush_first <= 1'b0;
            wait_q      <= 1'b0;
            wr_q        <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < BURST_LEN; i++) begin
                buf_data[i] <= '0;
                buf_mask[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (st_en) begin
                buf_data[beat_of(st_addr)][{st_addr[2:1], 4'b0000} +: 16] <= st_dout;
                buf_mask[beat_of(st_addr)][{st_addr[2:1], 1'b0} +: 2]     <= 2'b11;
            end
            case (state)
                IDLE: begin
                    if (wr_acc) begin
                        tag_q   <= tag_of(bus.ioctl_addr);
                        final_q <= 1'b0;
                        if (is_last(bus.ioctl_addr)) begin
                            state       <= FLUSH;
                            wait_q      <= 1'b1;
                            wr_q        <= 1'b1;
                            beat_cnt    <= '0;
                            flush_first <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (wr_acc && same_tag) begin
                        if (is_last(bus.ioctl_addr)) begin
                            state       <= FLUSH;
                            wait_q      <= 1'b1;
                            wr_q        <= 1'b1;
                            beat_cnt    <= '0;
                            flush_first <= 1'b1;
                        end
                    end else if (wr_acc) begin
                        pend_vld    <= 1'b1;
                        pend_addr   <= bus.ioctl_addr;
                        pend_dout   <= bus.ioctl_dout;
                        state       <= FLUSH;
                        wait_q      <= 1'b1;
                        wr_q        <= 1'b1;
                        beat_cnt    <= '0;
                        flush_first <= 1'b1;
                    end else if (!bus.ioctl_download) begin
                        final_q     <= 1'b1;
                        state       <= FLUSH;
                        wait_q      <= 1'b1;
                        wr_q        <= 1'b1;
                        beat_cnt    <= '0;
                        flush_first <= 1'b1;
                    end
                end
                FLUSH: begin
                    flush_first <= 1'b0;
                    if (!bus.ioctl_download) final_q <= 1'b1;
                    if (late_cap) begin
                        pend_vld  <= 1'b1;
                        pend_addr <= bus.ioctl_addr;
                        pend_dout <= bus.ioctl_dout;
                    end
                    if (beat_acc) begin
                        if (beat_cnt == LAST_BEAT) begin
                            for (int i = 0; i < BURST_LEN; i++) begin
                                buf_data[i] <= '0;
                                buf_mask[i] <= '0;
                            end
                            wr_q  <= 1'b0;
                            state <= POST;
                            // done lines up with the POST cycle that ends the download.
                            if (!(pend_vld || late_cap) && (final_q || !bus.ioctl_download))
                                done_q <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                POST: begin
                    if (pend_vld) begin
                        pend_vld <= 1'b0;
                        tag_q    <= tag_of(pend_addr);
                        final_q  <= 1'b0;
                        if (is_last(pend_addr)) begin
                            state       <= FLUSH;
                            wr_q        <= 1'b1;
                            beat_cnt    <= '0;
                            flush_first <= 1'b1;
                        end else begin
                            state  <= FILL;
                            wait_q <= 1'b0;
                        end
                    end else begin
                        state   <= IDLE;
                        wait_q  <= 1'b0;
                        final_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data-side outputs read straight from the buffer and are zero outside a burst.
    assign bus.ioctl_wait      = wait_q;
    assign bus.ddr_wr          = wr_q;
    assign bus.ddr_burstLength = 8'(BURST_LEN);
    assign bus.ddr_addr        = wr_q ? (BASE_ADDR + (32'(tag_q) << (3 + BW))) : '0;
    assign bus.ddr_mask        = wr_q ? buf_mask[beat_cnt] : '0;
    assign bus.ddr_din         = wr_q ? buf_data[beat_cnt] : '0;
    assign busy                = state != IDLE;
    assign done                = done_q;
endmodule

// File: tb/tb_ioctl_ddr_writer.sv
// Randomized scoreboard bench for ioctl_ddr_writer: a block-image reference model
// queues expected bursts, and a monitor checks each beat and done pulse against it.
module tb_ioctl_ddr_writer;
    localparam int BL = 8;

    logic clk;
    logic rst;
    logic busy;
    logic done;

    ioctl_ddr_writer_if bus();

    ioctl_ddr_writer #(
        .BASE_ADDR(32'h3000_0000),
        .BURST_LEN(BL),
        .INDEX(8'd0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy),
        .done(done)
    );

    typedef struct {
        logic [31:0]  addr;
        logic [511:0] data;
        logic [63:0]  mask;
        bit           fin;
    } burst_t;

    burst_t      exp_q[$];
    burst_t      mon_e;
    logic [31:0] seen_addr[$];
    logic [63:0] seen_d0[$];
    logic [7:0]  seen_m0[$];

    int checks     = 0;
    int errors     = 0;
    int mon_beat   = 0;
    int done_cnt   = 0;
    int stall_seen = 0;
    int wreq_mode  = 0;
    int st0        = 0;
    int st5        = 0;
    bit done_pend  = 0;
    bit mon_en     = 1;

    bit           m_open = 0;
    int           m_tag  = 0;
    logic [511:0] m_d;
    logic [63:0]  m_m;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one open block image; a burst leaves when the block is
    // abandoned for another tag, completed at its top lane, or the download ends.
    task automatic emit(input bit fin);
        burst_t e;
        e.addr = 32'h3000_0000 + 32'(m_tag * 64);
        e.data = m_d;
        e.mask = m_m;
        e.fin  = fin;
        exp_q.push_back(e);
        m_open = 0;
    endtask

    task automatic model_write(input logic [26:0] a, input logic [15:0] d);
        int tag;
        int b;
        int lane;
        tag  = int'(a >> 6);
        b    = int'((a >> 3) & 27'd7);
        lane = int'((a >> 1) & 27'd3);
        if (m_open && tag != m_tag) emit(0);
        if (!m_open) begin
            m_open = 1;
            m_tag  = tag;
            m_d    = '0;
            m_m    = '0;
        end
        m_d[b*64 + lane*16 +: 16] = d;
        m_m[b*8 + lane*2 +: 2]    = 2'b11;
        if ((a & 27'h3e) == 27'h3e) emit(0);
    endtask

    task automatic model_end();
        if (m_open) emit(1);
    endtask

    always @(posedge clk) begin
        #1;
        if (!bus.ddr_wr) begin
            st0 = 0;
            st5 = 0;
            bus.ddr_waitReq = (wreq_mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
        end else begin
            case (wreq_mode)
                1: bus.ddr_waitReq = ($urandom_range(0, 3) == 0);
                2: begin
                    if (mon_beat == 0 && st0 < 3) begin
                        st0++;
                        bus.ddr_waitReq = 1'b1;
                    end else if (mon_beat == 5 && st5 < 3) begin
                        st5++;
                        bus.ddr_waitReq = 1'b1;
                    end else begin
                        bus.ddr_waitReq = 1'b0;
                    end
                end
                default: bus.ddr_waitReq = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (done) begin
                done_cnt++;
                checks++;
                if (!done_pend) begin
                    errors++;
                    $display("FAIL done_spurious: got 1 expected 0");
                end
                done_pend = 0;
            end else if (done_pend) begin
                checks++;
                errors++;
                $display("FAIL done_missing: got 0 expected 1 after final burst");
                done_pend = 0;
            end
            if (bus.ddr_wr && bus.ddr_waitReq) stall_seen++;
            if (bus.ddr_wr && !bus.ddr_waitReq) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected: got beat at %h expected none", bus.ddr_addr);
                end else begin
                    mon_e = exp_q[0];
                    chk("beat_addr", 64'(bus.ddr_addr), 64'(mon_e.addr));
                    chk("beat_din", bus.ddr_din, mon_e.data[mon_beat*64 +: 64]);
                    chk("beat_mask", 64'(bus.ddr_mask), 64'(mon_e.mask[mon_beat*8 +: 8]));
                    chk("wait_in_burst", 64'(bus.ioctl_wait), 64'd1);
                    chk("burst_len", 64'(bus.ddr_burstLength), 64'(BL));
                    if (mon_beat == 0) begin
                        seen_addr.push_back(bus.ddr_addr);
                        seen_d0.push_back(bus.ddr_din);
                        seen_m0.push_back(bus.ddr_mask);
                    end
                    mon_beat++;
                    if (mon_beat == BL) begin
                        mon_beat = 0;
                        if (mon_e.fin) done_pend = 1;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.ioctl_wait && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout: got ioctl_wait 1 expected 0 within 300 cycles");
        end
    endtask

    task automatic do_write(input logic [26:0] a, input logic [15:0] d);
        wait_ready();
        bus.ioctl_index = 8'd0;
        bus.ioctl_addr  = a;
        bus.ioctl_dout  = d;
        bus.ioctl_wr    = 1'b1;
        model_write(a, d);
        @(negedge clk);
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic bad_write(input logic [26:0] a, input logic [15:0] d);
        bus.ioctl_index = 8'd1;
        bus.ioctl_addr  = a;
        bus.ioctl_dout  = d;
        bus.ioctl_wr    = 1'b1;
        @(negedge clk);
        bus.ioctl_wr    = 1'b0;
        bus.ioctl_index = 8'd0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d queued bursts expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic start_dl();
        bus.ioctl_index    = 8'd0;
        bus.ioctl_download = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_dl();
        wait_ready();
        bus.ioctl_download = 1'b0;
        model_end();
        @(negedge clk);
        drain();
    endtask

    task automatic clear_seen();
        seen_addr.delete();
        seen_d0.delete();
        seen_m0.delete();
    endtask

    initial begin
        int d0;
        int n;
        int beats;
        logic [26:0] a;

        rst                = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.ddr_waitReq    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ddr_wr", 64'(bus.ddr_wr), 64'd0);
        chk("rst_ddr_addr", 64'(bus.ddr_addr), 64'd0);
        chk("rst_ddr_mask", 64'(bus.ddr_mask), 64'd0);
        chk("rst_ddr_din", bus.ddr_din, 64'd0);
        chk("rst_wait", 64'(bus.ioctl_wait), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_burst_len", 64'(bus.ddr_burstLength), 64'(BL));
        rst = 1'b0;
        @(negedge clk);

        // Full sequential block, no DDR back-pressure.
        wreq_mode = 0;
        clear_seen();
        start_dl();
        for (int i = 0; i < 32; i++) do_write(27'(i * 2), 16'(i));
        end_dl();
        chk("seq_bursts", 64'(seen_addr.size()), 64'd1);
        chk("seq_addr", 64'(seen_addr[0]), 64'h3000_0000);
        chk("seq_beat0", seen_d0[0], 64'h0003_0002_0001_0000);

        // Same block with three-cycle stalls on beats 0 and 5.
        wreq_mode  = 2;
        stall_seen = 0;
        clear_seen();
        start_dl();
        for (int i = 0; i < 32; i++) do_write(27'(i * 2), 16'(i));
        end_dl();
        wreq_mode = 0;
        chk("stall_bursts", 64'(seen_addr.size()), 64'd1);
        chk("stall_cycles", 64'(stall_seen), 64'd6);

        // Partial block closed by the end of the download.
        clear_seen();
        d0 = done_cnt;
        start_dl();
        do_write(27'd0, 16'h1111);
        do_write(27'd2, 16'h2222);
        do_write(27'd4, 16'h3333);
        end_dl();
        chk("partial_bursts", 64'(seen_addr.size()), 64'd1);
        chk("partial_mask0", 64'(seen_m0[0]), 64'h3F);
        chk("partial_done_count", 64'(done_cnt - d0), 64'd1);

        // Tag change: pending write opens block 1.
        clear_seen();
        d0 = done_cnt;
        start_dl();
        do_write(27'd0, 16'hA5A5);
        do_write(27'd64, 16'h5A5A);
        end_dl();
        chk("tag_bursts", 64'(seen_addr.size()), 64'd2);
        chk("tag_addr0", 64'(seen_addr[0]), 64'h3000_0000);
        chk("tag_addr1", 64'(seen_addr[1]), 64'h3000_0040);
        chk("tag_mask0", 64'(seen_m0[0]), 64'h03);
        chk("tag_done_count", 64'(done_cnt - d0), 64'd1);

        // Wrong index is ignored.
        start_dl();
        for (int i = 0; i < 4; i++) begin
            bad_write(27'(i * 2), 16'(16'hBEE0 + i));
            chk("badidx_idle", {61'd0, busy, bus.ddr_wr, bus.ioctl_wait}, 64'd0);
        end
        bus.ioctl_download = 1'b0;
        repeat (3) @(negedge clk);
        chk("badidx_after", {62'd0, busy, bus.ddr_wr}, 64'd0);

        // Reset in the middle of a burst.
        mon_en = 0;
        start_dl();
        do_write(27'd0, 16'h0BAD);
        do_write(27'd2, 16'h0BAD);
        do_write(27'd4, 16'h0BAD);
        bus.ioctl_download = 1'b0;
        n     = 0;
        beats = 0;
        while (!(bus.ddr_wr && beats == 3) && n < 200) begin
            if (bus.ddr_wr && !bus.ddr_waitReq) beats++;
            @(negedge clk);
            n++;
        end
        chk("rst_reached_beat3", 64'(beats), 64'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ddr_wr", 64'(bus.ddr_wr), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_wait", 64'(bus.ioctl_wait), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        m_open    = 0;
        mon_beat  = 0;
        done_pend = 0;
        @(negedge clk);
        mon_en = 1;
        clear_seen();
        start_dl();
        do_write(27'd8, 16'hC0DE);
        end_dl();
        chk("postrst_bursts", 64'(seen_addr.size()), 64'd1);
        chk("postrst_mask0", 64'(seen_m0[0]), 64'h00);
        chk("postrst_din0", seen_d0[0], 64'h0);

        // Randomized downloads with random back-pressure and gaps.
        wreq_mode = 1;
        for (int dl = 0; dl < 8; dl++) begin
            start_dl();
            a = 27'($urandom_range(0, 15) * 64 + $urandom_range(0, 31) * 2);
            n = int'($urandom_range(1, 40));
            for (int w = 0; w < n; w++) begin
                if ($urandom_range(0, 7) == 0)
                    a = 27'($urandom_range(0, 15) * 64 + $urandom_range(0, 31) * 2);
                if ($urandom_range(0, 9) == 0)
                    bad_write(27'($urandom_range(0, 15) * 64), 16'($urandom));
                do_write(a, 16'($urandom));
                a = a + 27'd2;
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
            end_dl();
        end
        wreq_mode = 0;
        drain();
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ioctl_ddr_writer.md
Name: ioctl_ddr_writer

Overview:
- Sits between hps_io's ROM download port and the DDR3 interface.
- Packs 16-bit ioctl download words into 64-bit beats, collects them into one aligned burst buffer, and writes each full or partial burst to DDR with Avalon-style wait handling.
- Throttles the HPS with ioctl_wait while a burst is being written.
- Feeds the ROM image that Main later reads back from DDR.

Parameters:
- BASE_ADDR, 32'h3000_0000, byte address in DDR where ioctl address 0 lands; must be aligned to 8*BURST_LEN.
- BURST_LEN, 8, number of 64-bit beats per burst; power of two, 1..128.
- INDEX, 8'd0, ioctl_index value accepted; all other indices are ignored.

Ports:
- clk  in  1  system clock (clk_sys domain).
- rst  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download in progress.
- ioctl_wr  in  1  single-cycle write strobe.
- ioctl_index  in  8  download index.
- ioctl_addr  in  27  byte address, always even.
- ioctl_dout  in  16  write data.
- ioctl_wait  out  1  stall request to hps_io.
- ddr_wr  out  1  DDR write request/beat valid.
- ddr_addr  out  32  burst byte address, 8-byte aligned.
- ddr_burstLength  out  8  beats in burst; always BURST_LEN.
- ddr_mask  out  8  byte enables of the current beat.
- ddr_din  out  64  beat data.
- ddr_waitReq  in  1  DDR busy; a beat is accepted when ddr_wr & ~ddr_waitReq.
- busy  out  1  not in IDLE.
- done  out  1  one-cycle pulse after the final flush of a download.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, buffer and all byte masks cleared, pending-write register empty. ddr_burstLength is constant BURST_LEN.
- Accepted write: ioctl_wr & ioctl_download & (ioctl_index==INDEX) & ~ioctl_wait.
- Address mapping:
  - Beat = ioctl_addr[3+log2(BURST_LEN)-1:3].
  - Lane = ioctl_addr[2:1]; lane n occupies bytes 2n..2n+1 (ioctl_dout[7:0] goes to byte 2n).
  - Block tag = ioctl_addr[26:3+log2(BURST_LEN)].
- Each accepted write stores its data and sets the two corresponding mask bits.
- States:
  - IDLE: the first accepted write latches the tag, stores the data, then goes to FILL.
  - FILL, same-tag write: store. If the write is the last lane of the last beat (low address bits all ones except bit 0), go to FLUSH on the next cycle.
  - FILL, different-tag write: capture it in the pending register, go to FLUSH.
  - FILL, ioctl_download falls: go to FLUSH with final=1.
  - FLUSH:
    - ddr_wr=1 on every beat.
    - ddr_addr = BASE_ADDR + (tag << (3+log2(BURST_LEN))), held for the whole burst.
    - Beat counter starts at 0 and advances only on acceptance; beats with mask 0 are still sent, with mask 0.
    - After beat BURST_LEN-1 is accepted: clear buffer and masks, drop ddr_wr the same cycle, and go to POST.
  - POST:
    - If a pending write exists: apply it as the first write of a new block and go to FILL.
    - Else if final: pulse done and go to IDLE.
    - Else: go to IDLE.
- ioctl_wait is 1 in FLUSH and POST and 0 otherwise, so the earliest next write after a completing write is accepted after the burst.
- A write arriving in the cycle a full block triggers FLUSH is already masked by ioctl_wait, registered at the transition; writes arriving during the transition cycle must not be lost. They are held by the pending register.
- Download falling edge while in IDLE: no flush and no done pulse.
- Download falling edge while in FLUSH: final=1 is latched, and done pulses after the current burst.
- ioctl_wr with the wrong index is ignored in every state.
- rst mid-burst: ddr_wr drops the next edge, and data is discarded.

Test Plan:
- BURST_LEN=8: 32 sequential writes, addr 0..62, data 16'h0000+i, no waitReq.
  - Exactly one burst at addr 32'h3000_0000.
  - Beat 0 din = 64'h0003_0002_0001_0000, mask 8'hFF on all 8 beats.
  - ioctl_wait high during the burst.
- Same stimulus with ddr_waitReq high for 3 cycles on beats 0 and 5: the beat counter holds, and all 8 beats are delivered once, in order.
- 3 writes (addr 0,2,4), then ioctl_download falls:
  - One burst; beat 0 mask 8'h3F, beats 1..7 mask 8'h00.
  - done pulses once, 1 cycle after the last beat.
- Write addr 0, then addr 64 (new block):
  - First burst at 3000_0000 with beat0 mask 8'h03.
  - The pending write starts block 1; after download ends, second burst at 3000_0040.
- Write with ioctl_index=1 -> no state change, ddr_wr stays 0.
- Assert rst during beat 3 of a burst -> ddr_wr=0, busy=0, ioctl_wait=0 on the next cycle; a new download then starts clean, with mask bits from before reset absent.
